vc_round_robin_arbiter: RTL and testbench

VC_ROUND_ROBIN_ARBITER -- requirements
Module: vc_rr_arbiter

---
 rtl/vc_round_robin_arbiter.sv | 169 ++++++++++++++++
 tb/tb_vc_round_robin_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_round_robin_arbiter.sv
// Two-VC (even/odd) round-robin flit arbiter: each VC grants one requester,
// buffers its flit, and sends it on cycles where polarity selects that VC.
module vc_rr_fsm #(
    parameter int unsigned NREQ = 3,
    parameter bit          VC   = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            polarity,
    input  logic            ready_in,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      sel,
    output logic            load,
    output logic            busy,
    output logic            snd
);
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        GRANT = 4'b0010,
        FULL  = 4'b0100,
        SEND  = 4'b1000
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] win;
    logic [1:0] ptr_next;
    logic [1:0] pick_idle;
    logic [1:0] pick_send;
    logic       any_req;
    logic       go;

    // First set request at or above p, wrapping at NREQ-1.
    function automatic logic [1:0] pick(input logic [NREQ-1:0] r, input logic [1:0] p);
        logic [1:0]  w;
        logic        found;
        int unsigned idx;
        w     = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(p) + k) % NREQ;
            if (!found && (((r >> idx) & NREQ'(1)) != '0)) begin
                w     = 2'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign any_req   = |req;
    assign go        = ready_in && (polarity == VC);
    assign ptr_next  = (win == 2'(NREQ - 1)) ? 2'b00 : 2'(win + 2'b01);
    assign pick_idle = pick(req, ptr);
    assign pick_send = pick(req, ptr_next);

    // Outputs are registered alongside the state so they track it exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
            win   <= '0;
            gnt   <= '0;
            sel   <= '0;
            load  <= 1'b0;
            busy  <= 1'b0;
            snd   <= 1'b0;
        end else begin
            gnt  <= '0;
            load <= 1'b0;
            busy <= 1'b0;
            snd  <= 1'b0;
            case (state)
                IDLE: begin
                    sel <= '0;
                    if (any_req) begin
                        state <= GRANT;
                        win   <= pick_idle;
                        sel   <= pick_idle;
                        gnt   <= NREQ'(1) << pick_idle;
                        load  <= 1'b1;
                    end
                end
                GRANT: begin
                    state <= FULL;
                    busy  <= 1'b1;
                end
                FULL: begin
                    busy <= 1'b1;
                    if (go) begin
                        state <= SEND;
                        snd   <= 1'b1;
                    end
                end
                SEND: begin
                    ptr <= ptr_next;
                    if (any_req) begin
                        state <= GRANT;
                        win   <= pick_send;
                        sel   <= pick_send;
                        gnt   <= NREQ'(1) << pick_send;
                        load  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        sel   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    sel   <= '0;
                end
            endcase
        end
    end
endmodule

module vc_round_robin_arbiter #(
    parameter int unsigned NREQ = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            polarity,
    input  logic            ready_in,
    input  logic [NREQ-1:0] req_even,
    input  logic [NREQ-1:0] req_odd,
    output logic [NREQ-1:0] gnt_even,
    output logic [NREQ-1:0] gnt_odd,
    output logic [1:0]      sel_even,
    output logic [1:0]      sel_odd,
    output logic            load_even,
    output logic            load_odd,
    output logic            busy_even,
    output logic            busy_odd,
    output logic            send,
    output logic            send_vc
);
    logic snd_even;
    logic snd_odd;

    vc_rr_fsm #(.NREQ(NREQ), .VC(1'b0)) u_even (
        .clk      (clk),
        .rst      (rst),
        .polarity (polarity),
        .ready_in (ready_in),
        .req      (req_even),
        .gnt      (gnt_even),
        .sel      (sel_even),
        .load     (load_even),
        .busy     (busy_even),
        .snd      (snd_even)
    );

    vc_rr_fsm #(.NREQ(NREQ), .VC(1'b1)) u_odd (
        .clk      (clk),
        .rst      (rst),
        .polarity (polarity),
        .ready_in (ready_in),
        .req      (req_odd),
        .gnt      (gnt_odd),
        .sel      (sel_odd),
        .load     (load_odd),
        .busy     (busy_odd),
        .snd      (snd_odd)
    );

    // Polarity keeps the two SEND states apart, so the odd flag alone names the VC.
    assign send    = snd_even | snd_odd;
    assign send_vc = snd_odd;
endmodule

// File: tb/tb_vc_round_robin_arbiter.sv
// Directed + random bench for vc_round_robin_arbiter against a transaction-level model.
module tb_vc_round_robin_arbiter;
    localparam int unsigned NREQ = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            polarity;
    logic            ready_in;
    logic [NREQ-1:0] req_even;
    logic [NREQ-1:0] req_odd;
    logic [NREQ-1:0] gnt_even;
    logic [NREQ-1:0] gnt_odd;
    logic [1:0]      sel_even;
    logic [1:0]      sel_odd;
    logic            load_even;
    logic            load_odd;
    logic            busy_even;
    logic            busy_odd;
    logic            send;
    logic            send_vc;

    int n_cmp = 0;
    int n_bad = 0;
    bit auto_pol = 1'b0;

    // Model: phase 0 idle, 1 granted, 2 buffered, 3 sending; owner and pointer per VC.
    int m_ph [2];
    int m_own[2];
    int m_ptr[2];

    always #5 clk = ~clk;

    vc_round_robin_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .polarity  (polarity),
        .ready_in  (ready_in),
        .req_even  (req_even),
        .req_odd   (req_odd),
        .gnt_even  (gnt_even),
        .gnt_odd   (gnt_odd),
        .sel_even  (sel_even),
        .sel_odd   (sel_odd),
        .load_even (load_even),
        .load_odd  (load_odd),
        .busy_even (busy_even),
        .busy_odd  (busy_odd),
        .send      (send),
        .send_vc   (send_vc)
    );

    // Rotate the request vector so the pointer sits at bit 0, take the lowest set bit.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        logic [2*NREQ-1:0] d;
        d = {r, r} >> p;
        for (int j = 0; j < int'(NREQ); j++)
            if (d[j]) return (p + j) % int'(NREQ);
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            m_ph[v]  = 0;
            m_own[v] = 0;
            m_ptr[v] = 0;
        end
    endtask

    task automatic model_step();
        logic [NREQ-1:0] r;
        for (int v = 0; v < 2; v++) begin
            r = (v == 1) ? req_odd : req_even;
            case (m_ph[v])
                0: if (r != '0) begin m_own[v] = rr_pick(r, m_ptr[v]); m_ph[v] = 1; end
                1: m_ph[v] = 2;
                2: if (ready_in && (int'(polarity) == v)) m_ph[v] = 3;
                default: begin
                    m_ptr[v] = (m_own[v] + 1) % int'(NREQ);
                    if (r != '0) begin m_own[v] = rr_pick(r, m_ptr[v]); m_ph[v] = 1; end
                    else m_ph[v] = 0;
                end
            endcase
        end
    endtask

    task automatic check_all();
        int exp_gnt[2];
        int exp_sel[2];
        for (int v = 0; v < 2; v++) begin
            exp_gnt[v] = (m_ph[v] == 1) ? (1 << m_own[v]) : 0;
            exp_sel[v] = (m_ph[v] == 0) ? 0 : m_own[v];
        end
        chk("gnt_even",  32'(gnt_even),  32'(exp_gnt[0]));
        chk("gnt_odd",   32'(gnt_odd),   32'(exp_gnt[1]));
        chk("sel_even",  32'(sel_even),  32'(exp_sel[0]));
        chk("sel_odd",   32'(sel_odd),   32'(exp_sel[1]));
        chk("load_even", 32'(load_even), 32'(m_ph[0] == 1));
        chk("load_odd",  32'(load_odd),  32'(m_ph[1] == 1));
        chk("busy_even", 32'(busy_even), 32'(m_ph[0] >= 2));
        chk("busy_odd",  32'(busy_odd),  32'(m_ph[1] >= 2));
        chk("send",      32'(send),      32'(m_ph[0] == 3 || m_ph[1] == 3));
        if (m_ph[0] == 3 || m_ph[1] == 3)
            chk("send_vc", 32'(send_vc), 32'(m_ph[1] == 3));
    endtask

    // One clock: model consumes the inputs seen at the edge, outputs checked 1ns later.
    task automatic tick();
        if (rst) model_step();
        @(posedge clk);
        #1;
        check_all();
        if (auto_pol) polarity = ~polarity;
    endtask

    initial begin
        int seen;
        logic [NREQ-1:0] gseq[$];

        rst = 1'b0; polarity = 1'b0; ready_in = 1'b0; req_even = '0; req_odd = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;

        // Single even request, polarity toggling.
        auto_pol = 1'b1; ready_in = 1'b1; req_even = 3'b001;
        seen = 0;
        for (int i = 0; i < 5 && seen == 0; i++) begin
            tick();
            if (gnt_even != '0) seen = 1;
        end
        chk("single_gnt_seen", 32'(seen), 32'd1);
        chk("single_gnt",  32'(gnt_even),  32'h1);
        chk("single_load", 32'(load_even), 32'h1);
        chk("single_sel",  32'(sel_even),  32'h0);
        req_even = '0;
        repeat (6) tick();
        chk("single_ptr_model", 32'(m_ptr[0]), 32'd1);

        // Fairness with all three even requesters held.
        req_even = 3'b111;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (gnt_even != '0) gseq.push_back(gnt_even);
        end
        req_even = '0;
        repeat (6) tick();
        chk("fair_count", 32'(gseq.size() >= 4), 32'd1);
        if (gseq.size() >= 4) begin
            chk("fair_g0", 32'(gseq[0]), 32'h2);
            chk("fair_g1", 32'(gseq[1]), 32'h4);
            chk("fair_g2", 32'(gseq[2]), 32'h1);
            chk("fair_g3", 32'(gseq[3]), 32'h2);
        end

        // Back-pressure: 20 cycles of ready_in=0 while buffered.
        ready_in = 1'b0; req_even = 3'b010;
        seen = 0;
        for (int i = 0; i < 5 && seen == 0; i++) begin
            tick();
            if (busy_even) seen = 1;
        end
        chk("bp_full_seen", 32'(seen), 32'd1);
        req_even = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_busy", 32'(busy_even), 32'd1);
            chk("bp_send", 32'(send), 32'd0);
        end
        ready_in = 1'b1;
        repeat (6) tick();

        // Both VCs requesting together.
        req_even = 3'b010; req_odd = 3'b100;
        tick();
        chk("both_gnt", {30'd0, gnt_even != '0, gnt_odd != '0}, 32'd3);
        req_even = '0; req_odd = '0;
        repeat (8) tick();

        // Wrap on the odd VC: move its pointer to 2, then request 011.
        req_odd = 3'b010;
        tick();
        req_odd = '0;
        repeat (6) tick();
        chk("wrap_ptr_model", 32'(m_ptr[1]), 32'd2);
        gseq.delete();
        req_odd = 3'b011;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (gnt_odd != '0) gseq.push_back(gnt_odd);
        end
        req_odd = '0;
        repeat (6) tick();
        chk("wrap_count", 32'(gseq.size() >= 2), 32'd1);
        if (gseq.size() >= 2) begin
            chk("wrap_g0", 32'(gseq[0]), 32'h1);
            chk("wrap_g1", 32'(gseq[1]), 32'h2);
        end

        // Asynchronous reset while buffered.
        ready_in = 1'b0; req_even = 3'b111;
        seen = 0;
        for (int i = 0; i < 5 && seen == 0; i++) begin
            tick();
            if (busy_even) seen = 1;
        end
        chk("rst_full_seen", 32'(seen), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_busy", 32'(busy_even), 32'd0);
        tick();
        rst = 1'b1; ready_in = 1'b1;
        tick();
        chk("rst_first_gnt", 32'(gnt_even), 32'h1);
        req_even = '0;
        repeat (6) tick();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            req_even = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            req_odd  = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            ready_in = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
